// File: rtl/audio_sample_fetcher.sv
// audio_sample_fetcher
//   Turns each rising edge of the divided sample clock into one 16-bit audio
//   sample. Samples are packed two per 32-bit flash word ([15:0] earlier,
//   [31:16] later). A word is read only on every other sample period; the
//   second sample comes from the word already latched. Supports play/pause,
//   forward/backward direction, restart and wrap-around of the region.
//
// Ports
//   in_clk              system clock (same domain as the clock divider)
//   reset               synchronous, active-high reset
//   sample_clk          divided clock; its rising edge starts a sample period
//   play                1 = play, 0 = pause
//   dir                 0 = forward, 1 = backward
//   restart             single-cycle pulse, rewinds to the region start for dir
//   flash_read          Avalon-MM read request
//   flash_address       word address of the read
//   flash_waitrequest   slave stall; request held while high
//   flash_readdatavalid read data valid
//   flash_readdata      read word
//   audio_sample        current sample, held between updates
//   sample_valid        one-cycle pulse when audio_sample updates
//   overrun_count       (SAMPLE_OVERRUN_CNT_EN only) ticks dropped while busy
//
// Build option
//   SAMPLE_OVERRUN_CNT_EN  adds the saturating overrun_count output.

module audio_sample_fetcher #(
    parameter int unsigned        ADDR_W     = 23,
    parameter logic [ADDR_W-1:0]  START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0]  END_ADDR   = 23'h07FFFF
) (
    input  logic              in_clk,
    input  logic              reset,
    input  logic              sample_clk,
    input  logic              play,
    input  logic              dir,
    input  logic              restart,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    input  logic              flash_waitrequest,
    input  logic              flash_readdatavalid,
    input  logic [31:0]       flash_readdata,
    output logic [15:0]       audio_sample,
    output logic              sample_valid
`ifdef SAMPLE_OVERRUN_CNT_EN
    ,
    output logic [15:0]       overrun_count
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitData} state_e;

    state_e            state_q, state_d;
    logic              sample_clk_q;
    logic              tick;
    logic              half_q;        // 1: second sample of latched word still pending
    logic              first_hi_q;    // 1: the half already played was [31:16]
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       audio_q;
    logic              valid_q;
    logic              restart_pend_q;
    logic [ADDR_W-1:0] addr_step;
    logic [ADDR_W-1:0] addr_rewind;
    logic [15:0]       other_half;

    assign tick = sample_clk & ~sample_clk_q;

    // Step with wrap at the region boundaries.
    always_comb begin
        addr_step = addr_q;
        if (dir == 1'b0) begin
            addr_step = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
        end else begin
            addr_step = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
        end
    end

    assign addr_rewind = dir ? END_ADDR : START_ADDR;
    assign other_half  = first_hi_q ? word_q[15:0] : word_q[31:16];

    // ---------------------------------------------------------------- state register
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // Restart beats a coincident tick.
                if (!restart && tick && play && !half_q) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!flash_waitrequest) begin
                    state_d = StWaitData;
                end
            end
            StWaitData: begin
                if (flash_readdatavalid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        flash_read    = (state_q == StReq);
        flash_address = addr_q;
        audio_sample  = audio_q;
        sample_valid  = valid_q;
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge in_clk) begin
        if (reset) begin
            sample_clk_q   <= 1'b0;
            half_q         <= 1'b0;
            first_hi_q     <= 1'b0;
            word_q         <= '0;
            addr_q         <= START_ADDR;
            audio_q        <= '0;
            valid_q        <= 1'b0;
            restart_pend_q <= 1'b0;
        end else begin
            sample_clk_q <= sample_clk;
            valid_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (restart) begin
                        addr_q         <= addr_rewind;
                        half_q         <= 1'b0;
                        restart_pend_q <= 1'b0;
                    end else if (tick && play && half_q) begin
                        audio_q <= other_half;
                        valid_q <= 1'b1;
                        half_q  <= 1'b0;
                        addr_q  <= addr_step;
                    end
                end
                StReq: begin
                    if (restart) begin
                        restart_pend_q <= 1'b1;
                    end
                end
                StWaitData: begin
                    if (flash_readdatavalid) begin
                        if (restart_pend_q || restart) begin
                            // Word is discarded; the rewind lands as we return to idle.
                            addr_q         <= addr_rewind;
                            half_q         <= 1'b0;
                            restart_pend_q <= 1'b0;
                        end else begin
                            word_q     <= flash_readdata;
                            first_hi_q <= dir;
                            audio_q    <= dir ? flash_readdata[31:16] : flash_readdata[15:0];
                            valid_q    <= 1'b1;
                            half_q     <= 1'b1;
                        end
                    end else if (restart) begin
                        restart_pend_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAMPLE_OVERRUN_CNT_EN
    logic [15:0] overrun_q;

    always_ff @(posedge in_clk) begin
        if (reset) begin
            overrun_q <= '0;
        end else if (restart) begin
            overrun_q <= '0;
        end else if (tick && play && (state_q != StIdle) && (overrun_q != 16'hFFFF)) begin
            overrun_q <= overrun_q + 16'd1;
        end
    end

    assign overrun_count = overrun_q;
`endif

endmodule
